// File: rtl/dc_vga_pkg.sv
// Shared VGA display-path definitions: fetch FSM states and pixel layout.
package dc_vga_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    STREAM   = 2'd2,
    FLUSH    = 2'd3
  } fetch_state_t;

  localparam int PIXEL_W = 24;
  localparam int COLOR_W = 8;
  localparam int R_LSB   = 0;
  localparam int G_LSB   = 8;
  localparam int B_LSB   = 16;

endpackage

// File: rtl/dc_sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy count and synchronous clear.
module dc_sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // A pop on an empty FIFO is ignored; a push on a full FIFO is accepted only
  // when a pop frees the slot in the same cycle, so nothing is ever lost.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Pixel storage, written on accepted pushes (data path, no reset).
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dc_line_fetch_scheduler.sv
// Frame pixel fetcher: streams H*V pixels from memory into a show-ahead FIFO
// feeding the VGA controller, with underflow detection and frame abort.
module dc_line_fetch_scheduler
  import dc_vga_pkg::*;
#(
  parameter int                    CONFIG_H_ACTIVE_SIZE = 640,
  parameter int                    CONFIG_V_ACTIVE_SIZE = 480,
  parameter int                    FIFO_DEPTH           = 16,
  parameter int                    ADDR_WIDTH           = 19,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR            = '0
) (
  input  logic                  iVGA_CLK,
  input  logic                  iRST,
  input  logic                  v_blank,
  input  logic                  pixel_ready,
  output logic                  pixel_valid,
  output logic [PIXEL_W-1:0]    pixel_data,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [PIXEL_W-1:0]    mem_rdata,
  output logic                  underflow,
  input  logic                  underflow_clr
);
  localparam int TOTAL = CONFIG_H_ACTIVE_SIZE * CONFIG_V_ACTIVE_SIZE;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int OW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [OW:0] DEPTH_LIM = (OW+1)'(FIFO_DEPTH);

  fetch_state_t     state;
  logic             v_blank_p1;
  logic             vb_rise;
  logic [CW-1:0]    requested;
  logic [CW-1:0]    popped;
  logic [OW-1:0]    outstanding;
  logic [OW-1:0]    fifo_count;
  logic             fifo_empty;
  logic             fifo_full;
  logic [PIXEL_W-1:0] fifo_head;
  logic [OW:0]      inflight;
  logic             fetch_active;
  logic             req_fire;
  logic             rsp_take;
  logic             fifo_push;
  logic             fifo_pop;
  logic             underflow_set;

  assign vb_rise      = v_blank & ~v_blank_p1;
  assign fetch_active = (state == PREFETCH) || (state == STREAM);
  // FIFO entries plus reads in flight never exceed the FIFO depth, so every
  // returning read is guaranteed a slot.
  assign inflight     = {1'b0, fifo_count} + {1'b0, outstanding};
  assign mem_req      = fetch_active && (requested < CW'(TOTAL)) && (inflight < DEPTH_LIM);
  assign req_fire     = mem_req & mem_gnt;
  assign rsp_take     = mem_rvalid & (outstanding != '0);
  // Responses arriving during an abort belong to the dead frame and are dropped.
  assign fifo_push    = rsp_take & (state != FLUSH);
  assign pixel_valid  = (state == STREAM) & ~fifo_empty;
  assign pixel_data   = pixel_valid ? fifo_head : '0;
  assign fifo_pop     = pixel_valid & pixel_ready;
  assign underflow_set = (state == STREAM) & pixel_ready & fifo_empty & (popped < CW'(TOTAL));

  dc_sync_fifo #(
    .WIDTH (PIXEL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (iVGA_CLK),
    .rst   (iRST),
    .clr   (state == FLUSH),
    .push  (fifo_push),
    .wdata (mem_rdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Registered copy of v_blank for rising-edge detection.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) v_blank_p1 <= 1'b0;
    else      v_blank_p1 <= v_blank;
  end

  // Fetch FSM with request address and frame request/pop counters.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      state     <= IDLE;
      mem_addr  <= BASE_ADDR;
      requested <= '0;
      popped    <= '0;
    end else begin
      if (req_fire) begin
        mem_addr  <= mem_addr + ADDR_WIDTH'(1);
        requested <= requested + CW'(1);
      end
      if (fifo_pop) popped <= popped + CW'(1);
      case (state)
        IDLE: begin
          if (vb_rise) begin
            state     <= PREFETCH;
            mem_addr  <= BASE_ADDR;
            requested <= '0;
            popped    <= '0;
          end
        end
        PREFETCH: begin
          if (fifo_full || (requested == CW'(TOTAL))) state <= STREAM;
        end
        STREAM: begin
          if (fifo_pop && (popped == CW'(TOTAL - 1))) state <= IDLE;
          else if (vb_rise)                           state <= FLUSH;
        end
        FLUSH: begin
          if (outstanding == '0) begin
            state     <= PREFETCH;
            mem_addr  <= BASE_ADDR;
            requested <= '0;
            popped    <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reads granted but not yet returned; a grant and a return together cancel.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      outstanding <= '0;
    end else begin
      case ({req_fire, rsp_take})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: ;
      endcase
    end
  end

  // Sticky underflow flag; a new underflow wins over a simultaneous clear.
  always_ff @(posedge iVGA_CLK) begin
    if (iRST)               underflow <= 1'b0;
    else if (underflow_set) underflow <= 1'b1;
    else if (underflow_clr) underflow <= 1'b0;
  end

endmodule

// File: doc/dc_line_fetch_scheduler.md
DC_LINE_FETCH_SCHEDULER -- requirements
Module: dc_line_fetch_scheduler

Interface
REQ-001 SHALL have parameter CONFIG_H_ACTIVE_SIZE, default 640, meaning active pixels per line.
REQ-002 SHALL have parameter CONFIG_V_ACTIVE_SIZE, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning pixel FIFO entries (power of 2, >=4).
REQ-004 SHALL have parameter ADDR_WIDTH, default 19, meaning pixel address width.
REQ-005 SHALL have parameter BASE_ADDR, default 0, meaning address of frame pixel 0.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 SHALL have port iVGA_CLK, input, 1, the pixel clock.
REQ-008 SHALL have port iRST, input, 1, the synchronous active-high reset.
REQ-009 SHALL have port v_blank, input, 1, vertical blanking from the VGA controller.
REQ-010 SHALL have port pixel_ready, input, 1, VGA controller accepting a pixel.
REQ-011 SHALL have port pixel_valid, output, 1, FIFO head valid.
REQ-012 SHALL have port pixel_data, output, 24, {B,G,R} 8 bits each.
REQ-013 SHALL have port mem_req, output, 1, read request.
REQ-014 SHALL have port mem_addr, output, ADDR_WIDTH, read address.
REQ-015 SHALL have port mem_gnt, input, 1, request accepted this cycle.
REQ-016 SHALL have port mem_rvalid, input, 1, read data valid (in order, one per grant).
REQ-017 SHALL have port mem_rdata, input, 24, read pixel.
REQ-018 SHALL have port underflow, output, 1, sticky underflow flag.
REQ-019 SHALL have port underflow_clr, input, 1, clears underflow.

Function
REQ-020 SHALL implement FSM states IDLE, PREFETCH, STREAM, FLUSH.
REQ-021 SHALL go IDLE->PREFETCH on the v_blank rising edge (registered compare): reset the request address to BASE_ADDR and zero the request and pop counters.
REQ-022 SHALL issue mem_req in PREFETCH/STREAM while requested < H*V and fifo_count+outstanding < FIFO_DEPTH.
REQ-023 SHALL hold mem_req/mem_addr stable until mem_gnt, then increment mem_addr by 1 and outstanding by 1.
REQ-024 SHALL write mem_rdata into the FIFO on mem_rvalid and decrement outstanding; a simultaneous grant and rvalid leaves outstanding unchanged.
REQ-025 SHALL go PREFETCH->STREAM when the FIFO is full or all H*V pixels are requested.
REQ-026 SHALL drive pixel_valid = FIFO not empty in STREAM only; pixel_data = FIFO head (show-ahead), stable while pixel_valid & !pixel_ready.
REQ-027 SHALL pop on pixel_valid & pixel_ready, with simultaneous push and pop on a full or empty FIFO handled losslessly.
REQ-028 SHALL go STREAM->IDLE when pops reach H*V.
REQ-029 SHALL set underflow in STREAM when pixel_ready=1, FIFO empty and pops < H*V; underflow_clr clears it, and set wins over a simultaneous clear.
REQ-030 SHALL go STREAM->FLUSH on a v_blank rising edge with pops < H*V (frame abort); FLUSH empties the FIFO, drops mem_req, and discards rvalid data until outstanding = 0, then enters PREFETCH.
REQ-031 SHALL never exceed FIFO_DEPTH entries, so no overflow is possible by construction.
REQ-032 SHALL size counters to $clog2(H*V+1) and $clog2(FIFO_DEPTH+1) bits, with no wrap within a frame.

Reset
REQ-033 SHALL, while iRST=1 on a clock edge, clear state to IDLE, FIFO/outstanding/counters to 0, mem_addr to BASE_ADDR, and pixel_valid, mem_req and underflow to 0.
REQ-034 SHALL abandon in-flight reads on reset mid-frame; the environment also resets memory.

Structure
REQ-035 SHALL place FSM state enum, pixel width (24) and colour field offsets in shared package dc_vga_pkg.
REQ-036 SHALL implement the FIFO as sub-module dc_sync_fifo (show-ahead, count output).

Verification (H=8, V=2, DEPTH=4, BASE=0x100, memory latency 2, data = address)
REQ-037 SHALL cover a nominal frame: v_blank rise, pixel_ready pulses -> 16 pixels 0x100..0x10F in order, underflow=0, FSM returns IDLE.
REQ-038 SHALL cover backpressure: pixel_ready low 10 cycles -> pixel_data held, at most 4 reads outstanding+queued, no mem_req while full.
REQ-039 SHALL cover grant stall: mem_gnt low 5 cycles -> mem_addr held constant, no duplicate or skipped address.
REQ-040 SHALL cover underflow: latency 20, pixel_ready constant -> underflow=1 until underflow_clr, data order intact.
REQ-041 SHALL cover abort: v_blank rise after 5 pops with 2 reads outstanding -> FLUSH discards 2 responses, next frame starts at 0x100.
REQ-042 SHALL cover reset mid-STREAM: iRST one cycle -> all outputs 0 next cycle, mem_addr=0x100.
